toggle_burst_ctrl: RTL and testbench
====================================

Name: toggle_burst_ctrl

Overview:
Sequencer for the single-bit toggle output. It generates a burst of square pulses on y with programmable high time, low time and pulse count, started and stopped by a start/abort handshake. It replaces the free-running zero/one toggler wherever firmware or a higher-level FSM needs bounded, shaped toggling with busy and done status.

Parameters:
CNT_W, 8, width of high_len/low_len period fields and the internal period counter
NUM_W, 8, width of num_pulses and pulse_cnt

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
start  input  1  request a burst; sampled only in IDLE
abort  input  1  terminate the running burst; sampled only in HIGH/LOW
high_len  input  CNT_W  cycles y is high per pulse; 0 treated as 1
low_len  input  CNT_W  cycles y is low per pulse; 0 treated as 1
num_pulses  input  NUM_W  pulses per burst; 0 means empty burst
y  output  1  registered toggle output
busy  output  1  registered; high while in HIGH or LOW
done  output  1  registered; one-cycle pulse at burst end (normal, empty or aborted)
pulse_cnt  output  NUM_W  registered; completed pulses in the current or last burst

Behaviour:
- Reset is asynchronous and active-high: clk and rst, rst asynchronous active-high. While rst=1: state=IDLE, y=0, busy=0, done=0, pulse_cnt=0, period counter=0, shadow registers=0. Outputs clear immediately without a clock edge. No done pulse on reset.
- States: IDLE, HIGH, LOW, DONE. All outputs come straight from registers, with no combinational path from input to output.
- IDLE: start=1 at posedge latches high_len, low_len and num_pulses into shadow registers and clears pulse_cnt.
  - If num_pulses==0: next state is DONE.
  - Otherwise: next state is HIGH, with y=1 and busy=1 from that edge onward.
- Shadowed inputs: input changes while busy have no effect. start outside IDLE is ignored, including during DONE.
- Effective lengths: H = max(high_len,1) and L = max(low_len,1), taken from the shadow values.
- HIGH: y=1 for exactly H cycles. On the edge ending the H-th cycle, next state is LOW with y=0.
- LOW: y=0 for exactly L cycles. On the edge ending the L-th cycle, pulse_cnt increments.
  - If the new pulse_cnt equals num_pulses: next state is DONE.
  - Otherwise: next state is HIGH with y=1.
- Period counter resets to 0 on every HIGH/LOW entry.
- DONE: lasts exactly one cycle with done=1, busy=0, y=0. Next state is IDLE and done returns to 0.
- Normal burst timing: busy is high for exactly num_pulses*(H+L) cycles, immediately followed by a one-cycle done.
- abort=1 at a posedge in HIGH or LOW: next state is DONE with y=0 and busy=0.
  - abort overrides any concurrent HIGH/LOW transition.
  - If abort coincides with the last LOW cycle, that pulse still counts (pulse_cnt increments).
  - abort in IDLE or DONE is ignored.
- pulse_cnt holds its value through DONE and IDLE until the next accepted start.
- Counters are sized to their fields and never wrap: the period counter never exceeds 2^CNT_W-1, and pulse_cnt never exceeds num_pulses.
- Reset asserted mid-burst aborts with no done pulse. After rst deasserts, the first accepted start behaves as from power-up.

Test Plan:
1. Assert rst with no clk edges -> y=0, busy=0, done=0, pulse_cnt=0 immediately. Release rst -> remains IDLE; abort pulses have no effect.
2. high_len=3, low_len=2, num_pulses=2, start for one cycle -> from the next cycle y is 1,1,1,0,0,1,1,1,0,0 and busy is high for those 10 cycles. done=1 on cycle 11 only; pulse_cnt=2 afterwards.
3. high_len=0, low_len=0, num_pulses=3 -> y is 1,0,1,0,1,0 (treated as 1/1). done on cycle 7. Changing high_len to 5 mid-burst does not change the pattern.
4. num_pulses=0, start -> busy never asserts and y stays 0. done=1 exactly one cycle after start; pulse_cnt=0.
5. high_len=4, low_len=4, num_pulses=5; assert abort on the 2nd cycle of pulse 2's HIGH -> y=0 and busy=0 at the next edge, done pulses once, pulse_cnt=1. Second case: abort on the final LOW cycle of pulse 1 -> pulse_cnt=1.
6. Assert rst asynchronously mid-LOW of a running burst -> all outputs 0 immediately, no done. A start re-issued during busy of a fresh burst is ignored, and the burst completes with its original parameters.

Source files
------------

// File: rtl/toggle_burst_ctrl.sv
// toggle_burst_ctrl
// Generates a bounded burst of square pulses on y. Each pulse is high for
// max(high_len,1) cycles and low for max(low_len,1) cycles, repeated
// num_pulses times. A burst is started by start (in IDLE) and may be cut short
// by abort (in HIGH/LOW). All outputs are registered; burst parameters are
// shadowed at the accepted start so input changes mid-burst have no effect.
module toggle_burst_ctrl #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             y,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] sh_high;
    logic [CNT_W-1:0] sh_low;
    logic [NUM_W-1:0] sh_num;

    logic [CNT_W-1:0] high_last_idx;
    logic [CNT_W-1:0] low_last_idx;
    logic             high_last;
    logic             low_last;
    logic [NUM_W-1:0] pulse_inc;
    logic             burst_end;

    // Index of the final cycle of a phase; a zero length behaves as one cycle,
    // so the last index saturates at zero instead of wrapping to all-ones.
    function automatic logic [CNT_W-1:0] last_idx(input logic [CNT_W-1:0] len);
        logic [CNT_W-1:0] idx;
        if (len == '0) begin
            idx = '0;
        end else begin
            idx = len - CNT_W'(1);
        end
        return idx;
    endfunction

    // Phase-end and burst-end decode from the shadowed parameters.
    always_comb begin
        high_last_idx = last_idx(sh_high);
        low_last_idx  = last_idx(sh_low);
        high_last     = (period_cnt == high_last_idx);
        low_last      = (period_cnt == low_last_idx);
        pulse_inc     = pulse_cnt + NUM_W'(1);
        burst_end     = low_last && (pulse_inc == sh_num);
    end

    // Burst sequencer: state, period counter, shadow registers and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            period_cnt <= '0;
            sh_high    <= '0;
            sh_low     <= '0;
            sh_num     <= '0;
            y          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pulse_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh_high    <= high_len;
                        sh_low     <= low_len;
                        sh_num     <= num_pulses;
                        pulse_cnt  <= '0;
                        period_cnt <= '0;
                        if (num_pulses == '0) begin
                            // Empty burst: report completion without toggling.
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_HIGH;
                            y     <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end

                S_HIGH: begin
                    if (abort) begin
                        state      <= S_DONE;
                        y          <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        period_cnt <= '0;
                    end else if (high_last) begin
                        state      <= S_LOW;
                        y          <= 1'b0;
                        period_cnt <= '0;
                    end else begin
                        period_cnt <= period_cnt + CNT_W'(1);
                    end
                end

                S_LOW: begin
                    // A pulse completing on the same edge as abort still counts.
                    if (low_last) begin
                        pulse_cnt <= pulse_inc;
                    end
                    if (abort || burst_end) begin
                        state      <= S_DONE;
                        y          <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        period_cnt <= '0;
                    end else if (low_last) begin
                        state      <= S_HIGH;
                        y          <= 1'b1;
                        period_cnt <= '0;
                    end else begin
                        period_cnt <= period_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // Single-cycle completion strobe; start is not accepted here.
                    state <= S_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state      <= S_IDLE;
                    period_cnt <= '0;
                    y          <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_burst_ctrl.sv
// Bench for toggle_burst_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a burst-timeline model.
module tb_toggle_burst_ctrl;
    localparam int CNT_W = 8;
    localparam int NUM_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] high_len = '0;
    logic [CNT_W-1:0] low_len = '0;
    logic [NUM_W-1:0] num_pulses = '0;
    logic             y;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulse_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    toggle_burst_ctrl #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .high_len   (high_len),
        .low_len    (low_len),
        .num_pulses (num_pulses),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .pulse_cnt  (pulse_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a burst is a timeline of N*(H+L) cycles indexed by m_t.
    // y is high in the first H cycles of each H+L period; completed pulses = m_t/(H+L).
    bit m_active = 1'b0;
    bit m_done = 1'b0;
    int m_t = 0;
    int m_h = 1;
    int m_l = 1;
    int m_n = 0;
    int m_pcnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_t      = 0;
            m_pcnt   = 0;
        end else if (m_active) begin
            if (abort || m_t == m_n * (m_h + m_l) - 1) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_pcnt   = (m_t + 1) / (m_h + m_l);
            end else begin
                m_t++;
                m_pcnt = m_t / (m_h + m_l);
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            m_h    = (high_len == '0) ? 1 : int'(high_len);
            m_l    = (low_len == '0) ? 1 : int'(low_len);
            m_n    = int'(num_pulses);
            m_t    = 0;
            m_pcnt = 0;
            if (m_n == 0) m_done = 1'b1;
            else m_active = 1'b1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("y", int'(y), int'(m_active && ((m_t % (m_h + m_l)) < m_h)));
            check("busy", int'(busy), int'(m_active));
            check("done", int'(done), int'(m_done));
            check("pulse_cnt", int'(pulse_cnt), m_pcnt);
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", int'(n < budget), 1);
        @(negedge clk);
    endtask

    // Drive start with the given parameters for one cycle; returns at the
    // negedge of the first cycle after the accepting edge.
    task automatic launch(input int h, input int l, input int n);
        @(negedge clk);
        high_len   = CNT_W'(h);
        low_len    = CNT_W'(l);
        num_pulses = NUM_W'(n);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [9:0] pat2;
        logic [5:0] pat3;
        int busy_cycles;

        // 1. Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_y", int'(y), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pulse_cnt", int'(pulse_cnt), 0);
        check_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_abort_busy", int'(busy), 0);
        check("idle_abort_done", int'(done), 0);
        abort = 1'b0;

        // 2. Basic 3/2 x2 burst.
        pat2 = 10'b1110011100;
        launch(3, 2, 2);
        for (int i = 0; i < 10; i++) begin
            check("t2_y", int'(y), int'(pat2[9-i]));
            check("t2_busy", int'(busy), 1);
            @(negedge clk);
        end
        check("t2_done", int'(done), 1);
        check("t2_pulse_cnt", int'(pulse_cnt), 2);
        @(negedge clk);
        check("t2_done_clear", int'(done), 0);
        check("t2_pulse_cnt_hold", int'(pulse_cnt), 2);

        // 3. Zero lengths behave as 1; mid-burst input change is ignored.
        pat3 = 6'b101010;
        launch(0, 0, 3);
        for (int i = 0; i < 6; i++) begin
            check("t3_y", int'(y), int'(pat3[5-i]));
            if (i == 1) high_len = 8'd5;
            @(negedge clk);
        end
        check("t3_done", int'(done), 1);
        check("t3_pulse_cnt", int'(pulse_cnt), 3);
        wait_idle(20);

        // 4. Empty burst.
        launch(3, 3, 0);
        check("t4_done", int'(done), 1);
        check("t4_busy", int'(busy), 0);
        check("t4_y", int'(y), 0);
        check("t4_pulse_cnt", int'(pulse_cnt), 0);
        @(negedge clk);
        check("t4_done_clear", int'(done), 0);

        // 5a. Abort in 2nd cycle of pulse 2's HIGH (cycle 10).
        launch(4, 4, 5);
        repeat (9) @(negedge clk);
        check("t5a_y_before", int'(y), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5a_y", int'(y), 0);
        check("t5a_busy", int'(busy), 0);
        check("t5a_done", int'(done), 1);
        check("t5a_pulse_cnt", int'(pulse_cnt), 1);
        @(negedge clk);
        check("t5a_done_once", int'(done), 0);

        // 5b. Abort on the final LOW cycle of pulse 1 (cycle 8): pulse counts.
        launch(4, 4, 5);
        repeat (7) @(negedge clk);
        check("t5b_y_before", int'(y), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5b_done", int'(done), 1);
        check("t5b_pulse_cnt", int'(pulse_cnt), 1);
        wait_idle(20);

        // 6. Asynchronous reset mid-LOW, then start during busy is ignored.
        launch(3, 3, 4);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_y", int'(y), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_done", int'(done), 0);
        check("t6_rst_pulse_cnt", int'(pulse_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        check("t6_no_done", int'(done), 0);
        launch(2, 1, 2);
        start = 1'b1;
        high_len = 8'd5;
        num_pulses = 8'd4;
        busy_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                check("t6_pulse_cnt", int'(pulse_cnt), 2);
                break;
            end
            @(negedge clk);
        end
        check("t6_busy_cycles", busy_cycles, 6);
        wait_idle(20);

        // Long-phase boundary: 255-cycle HIGH keeps counter in range.
        launch(255, 1, 1);
        wait_idle(400);
        check("long_pulse_cnt", int'(pulse_cnt), 1);

        // Randomized traffic with occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start      = ($urandom_range(0, 3) == 0);
            abort      = ($urandom_range(0, 23) == 0);
            high_len   = CNT_W'($urandom_range(0, 5));
            low_len    = CNT_W'($urandom_range(0, 5));
            num_pulses = NUM_W'($urandom_range(0, 4));
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        check("global_timeout", 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
